// File: rtl/featuremap_conv2d_multich_pkg.sv
// conv_fx_pkg: shared FSM states, pipeline constants and the
// fixed-point round/ReLU/saturate helper for the 3x3 conv block.
package conv_fx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int PIPE_LAT = 3;
  localparam int TAPS     = 9;

  function automatic int bias_addr(input int ch);
    return TAPS * ch;
  endfunction

  // Round half up, drop frac bits, optional ReLU, clamp to dw bits.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] v,
    input int                 frac,
    input int                 dw,
    input logic               relu
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (v + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (relu && r < 64'sd0) r = 64'sd0;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/featuremap_conv2d_multich_if.sv
// featuremap_conv2d_multich_if: config, pixel-stream and result
// signals of the conv block, as seen by its driver and by the block.
interface featuremap_conv2d_multich_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH         = 3
);
  localparam int AW = $clog2(9 * CH + 1);

  logic                         cfg_we;
  logic [AW-1:0]                cfg_addr;
  logic signed [DATA_WIDTH-1:0] cfg_data;
  logic                         cfg_relu;
  logic                         start;
  logic [DATA_WIDTH*CH-1:0]     data_in;
  logic                         data_fifo_empty;
  logic                         rdreq;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         frame_done;
  logic                         busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_relu, start,
    output data_in, data_fifo_empty,
    input  rdreq, valid_out, data_out, frame_done, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_relu, start,
    input  data_in, data_fifo_empty,
    output rdreq, valid_out, data_out, frame_done, busy
  );

endinterface

// File: rtl/featuremap_conv2d_multich_line_window3x3.sv
// line_window3x3: two line buffers and a 3x3 window for one channel,
// exposed with the incoming pixel already in place as tap 8.
module line_window3x3 #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_W     = 114
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  output logic [9*DATA_WIDTH-1:0] win_out
);

  localparam int DEPTH = 2 * LINE_W + 2;

  logic [DATA_WIDTH-1:0] sr [DEPTH];

  // One chain holds both line buffers and the window columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= pix_in;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // Tap k = 3r+c sits (2-r) lines and (2-c) pixels behind pix_in.
  for (genvar k = 0; k < 9; k++) begin : g_tap
    localparam int J = (2 - k / 3) * LINE_W + (2 - k % 3);
    if (J == 0) begin : g_new
      assign win_out[k*DATA_WIDTH +: DATA_WIDTH] = pix_in;
    end else begin : g_old
      assign win_out[k*DATA_WIDTH +: DATA_WIDTH] = sr[J-1];
    end
  end

endmodule

// File: rtl/featuremap_conv2d_multich.sv
// featuremap_conv2d_multich: multi-channel 3x3 signed fixed-point conv
// with runtime weights/bias, optional ReLU and a frame-level FSM.
module featuremap_conv2d_multich
  import conv_fx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CH         = 3,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112,
  parameter int ACC_WIDTH  = 40
)(
  input logic                        clk,
  input logic                        rst,
  featuremap_conv2d_multich_if.slave bus
);

  localparam int NT = TAPS * CH;
  localparam int AW = $clog2(NT + 1);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HEIGHT + 2);
  localparam logic [AW-1:0] BADDR = AW'(bias_addr(CH));

  state_t                         state;
  state_t                         state_nx;
  logic [CW-1:0]                  col;
  logic [RW-1:0]                  row;
  logic [1:0]                     drain_cnt;
  logic                           relu_q;
  logic signed [DATA_WIDTH-1:0]   wt [NT];
  logic signed [DATA_WIDTH-1:0]   bias;
  logic                           accept;
  logic                           last_pix;
  logic                           win_ok;
  logic [9*DATA_WIDTH-1:0]        win [CH];
  logic signed [PW-1:0]           prod [NT];
  logic                           v1;
  logic                           v2;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_nx;
  logic signed [DATA_WIDTH-1:0]   res;

  assign accept   = (state == RUN) & ~bus.data_fifo_empty;
  assign last_pix = (col == CW'(WIDTH + 1)) &&
                    (row == RW'(HEIGHT + 1));
  assign win_ok   = accept && (col >= CW'(2)) && (row >= RW'(2));
  assign bus.rdreq = accept;
  assign bus.busy  = (state != IDLE);

  // Next-state logic: IDLE -> RUN on start, RUN -> DRAIN on last
  // pixel, DRAIN -> IDLE once the pipeline has flushed.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (accept && last_pix) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'(PIPE_LAT - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, ReLU latch, drain timer and the frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      relu_q         <= 1'b0;
      drain_cnt      <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nx;
      bus.frame_done <= (state == DRAIN) && (state_nx == IDLE);
      drain_cnt      <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == IDLE && bus.start) relu_q <= bus.cfg_relu;
    end
  end

  // Raster position of the next pixel; moves only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && bus.start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(WIDTH + 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Weight/bias register file, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) wt[i] <= '0;
      bias <= '0;
    end else if (state == IDLE && bus.cfg_we) begin
      if (bus.cfg_addr == BADDR) bias <= bus.cfg_data;
      for (int i = 0; i < NT; i++)
        if (bus.cfg_addr == AW'(i)) wt[i] <= bus.cfg_data;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    line_window3x3 #(
      .DATA_WIDTH (DATA_WIDTH),
      .LINE_W     (WIDTH + 2)
    ) u_win (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept),
      .pix_in   (bus.data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .win_out  (win[c])
    );
  end

  // S1: every tap of every channel times its weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < NT; i++) prod[i] <= '0;
    end else begin
      v1 <= win_ok;
      if (win_ok)
        for (int c = 0; c < CH; c++)
          for (int k = 0; k < TAPS; k++)
            prod[c*TAPS+k] <=
              PW'($signed(win[c][k*DATA_WIDTH +: DATA_WIDTH])) *
              PW'(wt[c*TAPS+k]);
    end
  end

  // S2 sum: bias aligned to the product scale plus all products.
  always_comb begin
    acc_nx = ACC_WIDTH'(bias) <<< FRAC_BITS;
    for (int i = 0; i < NT; i++)
      acc_nx = acc_nx + ACC_WIDTH'(prod[i]);
  end

  // S2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      acc <= '0;
    end else begin
      v2 <= v1;
      if (v1) acc <= acc_nx;
    end
  end

  assign res = DATA_WIDTH'(round_sat(64'(acc), FRAC_BITS,
                                     DATA_WIDTH, relu_q));

  // S3: rounded, rectified, saturated output pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      bus.valid_out <= v2;
      if (v2) bus.data_out <= res;
    end
  end

endmodule

// File: tb/tb_featuremap_conv2d_multich.sv
// tb_featuremap_conv2d_multich: directed frames on a 4x4 output map,
// 3 channels, Q8.8, with expected pixels and cycle timing.
module tb_featuremap_conv2d_multich;

  localparam int DW = 16;
  localparam int CH = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NT = 27;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_out = 0;

  typedef struct {
    string       nm;
    bit          ramp;
    logic [15:0] wall;
    logic [15:0] w4;
    logic [15:0] bias;
    logic [15:0] pix;
    bit          relu;
    bit          stall;
    bit          noise;
    bit          late;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    int          c;
  } exp_t;

  vec_t vt[10];
  vec_t vz;
  exp_t expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  featuremap_conv2d_multich_if #(.DATA_WIDTH(DW), .CH(CH)) bus();

  featuremap_conv2d_multich #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (8),
    .CH         (CH),
    .WIDTH      (W),
    .HEIGHT     (H),
    .ACC_WIDTH  (40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input bit ramp, input logic [15:0] wall,
    input logic [15:0] w4, input logic [15:0] bias,
    input logic [15:0] pix, input bit relu, input bit stall,
    input bit noise, input bit late, input logic [15:0] exp);
    vec_t v;
    v.nm = nm; v.ramp = ramp; v.wall = wall; v.w4 = w4;
    v.bias = bias; v.pix = pix; v.relu = relu; v.stall = stall;
    v.noise = noise; v.late = late; v.exp = exp;
    return v;
  endfunction

  function automatic logic [15:0] pixv(vec_t v, int ch, int r, int c);
    if (!v.ramp) return v.pix;
    case (ch)
      0:       return 16'(256 * (r * 6 + c + 1));
      1:       return 16'h0300;
      default: return 16'hFD00;
    endcase
  endfunction

  // Identity map: window completed at (r,c) outputs pixel (r-1,c-1).
  function automatic logic [15:0] expv(vec_t v, int r, int c);
    if (!v.ramp) return v.exp;
    return 16'(256 * ((r - 1) * 6 + c));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1 && bus.valid_out === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got=%h want=none",
                 $unsigned(bus.data_out));
      end else begin
        e = expq.pop_front();
        chk("data_out", $unsigned(bus.data_out), e.v);
        chk("latency", cyc, e.c);
      end
      last_out = cyc;
    end
  end

  task automatic load(vec_t v);
    for (int i = 0; i <= NT; i++) begin
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'(i);
      if (i == NT)     bus.cfg_data = v.bias;
      else if (i == 4) bus.cfg_data = v.late ? 16'h0000 : v.w4;
      else             bus.cfg_data = v.wall;
    end
    if (v.noise)
      for (int i = NT + 1; i < 32; i++) begin
        @(negedge clk);
        bus.cfg_addr = 5'(i);
        bus.cfg_data = 16'h4000;
      end
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic feed(vec_t v, int npix);
    int n;
    int g;
    int r;
    int c;
    n = 0;
    g = 0;
    bus.start    = 1'b1;
    bus.cfg_relu = v.relu;
    if (v.late) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'd4;
      bus.cfg_data = v.w4;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_relu = ~v.relu;
    chk({v.nm, "_busy_run"}, bus.busy, 1);
    while (n < npix && g < 1000) begin
      r = n / 6;
      c = n % 6;
      bus.data_in = {pixv(v, 2, r, c), pixv(v, 1, r, c),
                     pixv(v, 0, r, c)};
      bus.data_fifo_empty = v.stall ? ($urandom_range(0, 2) == 0)
                                    : 1'b0;
      if (v.noise) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = g[0] ? 5'd4 : 5'd27;
        bus.cfg_data = 16'h1234;
      end
      #1;
      chk({v.nm, "_rdreq"}, bus.rdreq, !bus.data_fifo_empty);
      if (!bus.data_fifo_empty) begin
        if (r >= 2 && c >= 2) expq.push_back('{expv(v, r, c), cyc + 3});
        n++;
      end
      @(negedge clk);
      g++;
    end
    bus.data_fifo_empty = 1'b1;
    bus.cfg_we          = 1'b0;
    if (n < npix) chk({v.nm, "_feed_timeout"}, n, npix);
  endtask

  task automatic wait_done(vec_t v);
    int k;
    k = 0;
    while (bus.frame_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({v.nm, "_frame_done"}, bus.frame_done, 1);
    chk({v.nm, "_done_timing"}, cyc, last_out + 1);
    chk({v.nm, "_outputs_left"}, expq.size(), 0);
    chk({v.nm, "_busy_idle"}, bus.busy, 0);
    @(negedge clk);
    chk({v.nm, "_done_pulse"}, bus.frame_done, 0);
  endtask

  initial begin
    bus.cfg_we          = 1'b0;
    bus.cfg_addr        = '0;
    bus.cfg_data        = '0;
    bus.cfg_relu        = 1'b0;
    bus.start           = 1'b0;
    bus.data_in         = '0;
    bus.data_fifo_empty = 1'b1;
    rst                 = 1'b1;

    vt[0] = mk("identity", 1, 16'h0000, 16'h0100, 16'h0000,
               16'h0000, 0, 0, 0, 0, 16'h0000);
    vt[1] = mk("bias_sum", 0, 16'h0100, 16'h0100, 16'h0080,
               16'h0010, 0, 0, 0, 0, 16'h0230);
    vt[2] = mk("sat_pos", 0, 16'h0100, 16'h0100, 16'h0000,
               16'h7F00, 0, 0, 0, 0, 16'h7FFF);
    vt[3] = mk("relu_neg", 0, 16'h0100, 16'h0100, 16'h0000,
               16'h8100, 1, 0, 0, 0, 16'h0000);
    vt[4] = mk("sat_neg", 0, 16'h0100, 16'h0100, 16'h0000,
               16'h8100, 0, 0, 0, 0, 16'h8000);
    vt[5] = mk("round_up", 0, 16'h0000, 16'h0080, 16'h0000,
               16'h0001, 0, 0, 0, 0, 16'h0001);
    vt[6] = mk("round_neg", 0, 16'h0000, 16'h0080, 16'h0000,
               16'hFFFF, 0, 0, 0, 0, 16'h0000);
    vt[7] = mk("stall", 1, 16'h0000, 16'h0100, 16'h0000,
               16'h0000, 0, 1, 0, 0, 16'h0000);
    vt[8] = mk("cfg_noise", 1, 16'h0000, 16'h0100, 16'h0000,
               16'h0000, 0, 0, 1, 1, 16'h0000);
    vt[9] = mk("relu_pos", 0, 16'h0100, 16'h0100, 16'h0080,
               16'h0010, 1, 0, 0, 0, 16'h0230);
    vz    = mk("cleared", 0, 16'h0000, 16'h0000, 16'h0000,
               16'h1234, 0, 0, 0, 0, 16'h0000);

    repeat (2) @(negedge clk);
    chk("rst_rdreq", bus.rdreq, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", $unsigned(bus.data_out), 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      load(vt[i]);
      feed(vt[i], 36);
      wait_done(vt[i]);
    end

    load(vt[1]);
    feed(vt[1], 22);
    #2 rst = 1'b1;
    expq.delete();
    #1;
    chk("midrst_data", $unsigned(bus.data_out), 0);
    chk("midrst_valid", bus.valid_out, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    feed(vz, 36);
    wait_done(vz);
    load(vt[0]);
    feed(vt[0], 36);
    wait_done(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/featuremap_conv2d_multich.md
Name: featuremap_conv2d_multich

Overview:
Parametrised successor to the fixed 3-channel, 3x3 feature-map convolution filters. It has these differences:
- Arithmetic is signed fixed point.
- The channel count is a parameter.
- Weights and bias are loaded at runtime through a config port instead of being elaboration constants.
- ReLU is optional.
- A frame-level FSM emits a frame_done pulse.

The block sits between the padded-pixel FIFO and the next layer's input FIFO. It computes one output feature map per frame.

Parameters:
DATA_WIDTH, 16, signed pixel/output width, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
FRAC_BITS, 8, fractional bits shared by pixels, weights and bias
CH, 3, number of input channels
WIDTH, 112, output columns (input frame is WIDTH+2 columns, zero-padded upstream)
HEIGHT, 112, output rows (input frame is HEIGHT+2 rows)
ACC_WIDTH, 40, accumulator width (must be >= 2*DATA_WIDTH+clog2(9*CH))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  write strobe for weight/bias register file
cfg_addr  in  clog2(9*CH+1)  0..9*CH-1 = weight (ch*9+k); 9*CH = bias
cfg_data  in  DATA_WIDTH  signed weight or bias, same Q format as pixels
cfg_relu  in  1  sampled at start; 1 = clamp negative results to 0
start  in  1  one-cycle pulse, begins a frame
data_in  in  DATA_WIDTH*CH  one padded pixel per channel; channel 0 in LSBs
data_fifo_empty  in  1  upstream FIFO empty
rdreq  out  1  pop upstream FIFO; a pixel is accepted in any cycle with rdreq=1
valid_out  out  1  data_out valid this cycle
data_out  out  DATA_WIDTH  signed output pixel
frame_done  out  1  one-cycle pulse after last output of a frame
busy  out  1  high in RUN and DRAIN

Behaviour:
- Reset (async, immediate): FSM=IDLE, counters 0, all weights and bias 0, relu_q=0, all pipeline valids 0. rdreq, valid_out, frame_done and busy are 0; data_out=0.
- FSM states:
  - IDLE: cfg writes accepted. start -> RUN, latching relu_q=cfg_relu and clearing col/row counters.
  - RUN: rdreq = ~data_fifo_empty. After the accepted pixel at col=WIDTH+1, row=HEIGHT+1 -> DRAIN.
  - DRAIN: stays for 3 cycles (pipeline flush) -> IDLE with frame_done=1 for exactly one cycle.
- cfg_we outside IDLE: ignored, register file unchanged. cfg_addr > 9*CH: ignored. start outside IDLE: ignored. start and cfg_we in the same IDLE cycle: the write lands; the frame uses the new value.
- Counters: col 0..WIDTH+1 and row 0..HEIGHT+1, advancing only on accepted pixels. col wraps to 0 and increments row.
- Window: k = 3*r + c. k=0 is top-left (oldest row, oldest column); k=8 is the newest pixel. A window is valid when an accepted pixel has col>=2 and row>=2, giving exactly WIDTH*HEIGHT outputs per frame.
- Pipeline, no output backpressure:
  - S1: 9*CH products, DATA_WIDTH x DATA_WIDTH signed, registered.
  - S2: adder tree over all products plus (bias <<< FRAC_BITS), in ACC_WIDTH, registered.
  - S3: add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS (round half up), apply ReLU if relu_q, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], registered.
  - valid_out is asserted 3 cycles after the accepting cycle of the completing pixel.
- FIFO empty mid-frame: no acceptance; counters and window hold. Pipeline stages already in flight still drain on schedule.
- rst asserted mid-frame: everything clears, including weights. Outputs already in flight are dropped.

Decomposition:
- Package conv_fx_pkg: FSM state enum {IDLE, RUN, DRAIN}; constants PIPE_LAT=3 and taps per channel = 9; function bias_addr(CH)=9*CH; saturate/round helper function.
- Sub-module line_window3x3 (params DATA_WIDTH, WIDTH+2), one instance per channel:
  - two line buffers plus a 3x3 shift-register window;
  - ports clk, rst, shift_en, pix_in, win_out[9*DATA_WIDTH].

Test Plan:
Bench configuration for all scenarios: WIDTH=HEIGHT=4, CH=3, FRAC_BITS=8.
- Identity: weight ch0 k4 = 0x0100, all other weights and bias 0; ch0 pixels = 0x0100*(row*6+col+1) -> 16 outputs equal to the interior ch0 pixels in raster order. Latency 3 after the completing pixel; frame_done one cycle after the last valid_out.
- Bias + channel sum: all 27 weights = 0x0100, bias = 0x0080, every pixel = 0x0010 -> every data_out = 27*0x10 + 0x80 = 0x0230.
- ReLU/saturation: all weights = 0x0100, pixels = 0x7F00.
  - With cfg_relu=0: data_out = 0x7FFF.
  - With pixels = 0x8100 and relu: data_out = 0x0000.
  - Same pixels without relu: data_out = 0x8000.
- Rounding: single tap = 0x0080 (0.5), pixel = 0x0001 -> raw 0x80 >> 8 with half-up rounding = 0x0001; pixel = 0xFFFF -> 0x0000.
- Stalls: data_fifo_empty toggles pseudo-randomly -> output sequence identical to the no-stall run. rdreq never high while empty.
- Illegal config / reset: cfg_we during RUN changes no output. rst pulsed mid-frame -> outputs 0 immediately, busy=0, a new start with reloaded weights gives correct results.
